// File: rtl/fcvt_int.sv
// Double-precision to signed 64-bit integer converter, truncating toward zero.
// A multicycle FSM shifts the mantissa one bit per cycle and collects the sticky bit.
module fcvt_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_int,
    output logic        out_nv,
    output logic        out_nx
);

    localparam logic [63:0] IntMax = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IntMin = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StShift,
        StSign,
        StDone
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [63:0] r_fp;
    logic [63:0] r_mag;
    logic [5:0]  r_count;
    logic        r_sticky;
    logic [63:0] r_out_int;
    logic        r_out_nv;
    logic        r_out_nx;

    logic               w_sign;
    logic [10:0]        w_exp;
    logic [51:0]        w_frac;
    logic               w_frac_nz;
    logic signed [11:0] w_e;
    logic [5:0]         w_k;
    logic               w_special;
    logic [63:0]        w_spec_int;
    logic               w_spec_nv;
    logic               w_spec_nx;

    assign w_sign    = r_fp[63];
    assign w_exp     = r_fp[62:52];
    assign w_frac    = r_fp[51:0];
    assign w_frac_nz = |w_frac;
    assign w_e       = $signed({1'b0, w_exp}) - 12'sd1023;
    assign w_k       = 6'd63 - w_e[5:0];

    // Operand classification; w_special clear means 0 <= e <= 62 and the shifter is needed.
    always_comb begin
        w_special  = 1'b1;
        w_spec_int = 64'd0;
        w_spec_nv  = 1'b0;
        w_spec_nx  = 1'b0;
        if (&w_exp) begin
            w_spec_nv  = 1'b1;
            w_spec_int = (w_frac_nz || !w_sign) ? IntMax : IntMin;
        end else if (w_exp == 11'd0) begin
            w_spec_nx = w_frac_nz;
        end else if (w_e < 0) begin
            w_spec_nx = 1'b1;
        end else if (w_e >= 12'sd63) begin
            w_spec_int = w_sign ? IntMin : IntMax;
            // -2^63 is the only e >= 63 value that is representable.
            w_spec_nv  = !(w_sign && (w_e == 12'sd63) && !w_frac_nz);
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StUnpack;
                end
            end
            StUnpack: begin
                w_state_next = w_special ? StDone : StShift;
            end
            StShift: begin
                // Leave on the cycle the count reaches zero.
                if (r_count <= 6'd1) begin
                    w_state_next = StSign;
                end
            end
            StSign: begin
                w_state_next = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fp      <= 64'd0;
            r_mag     <= 64'd0;
            r_count   <= 6'd0;
            r_sticky  <= 1'b0;
            r_out_int <= 64'd0;
            r_out_nv  <= 1'b0;
            r_out_nx  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_fp <= in_fp;
                    end
                end
                StUnpack: begin
                    if (w_special) begin
                        r_out_int <= w_spec_int;
                        r_out_nv  <= w_spec_nv;
                        r_out_nx  <= w_spec_nx;
                    end else begin
                        r_mag    <= {1'b1, w_frac, 11'b0};
                        r_count  <= w_k;
                        r_sticky <= 1'b0;
                    end
                end
                StShift: begin
                    if (r_count != 6'd0) begin
                        r_mag    <= r_mag >> 1;
                        r_sticky <= r_sticky | r_mag[0];
                        r_count  <= r_count - 6'd1;
                    end
                end
                StSign: begin
                    r_out_int <= w_sign ? (~r_mag + 64'd1) : r_mag;
                    r_out_nv  <= 1'b0;
                    r_out_nx  <= r_sticky;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_int = r_out_int;
    assign out_nv  = r_out_nv;
    assign out_nx  = r_out_nx;

endmodule

// File: tb/tb_fcvt_int.sv
// Directed bench for fcvt_int: special cases, truncation, latency, handshake hold,
// mid-conversion reset and integer round trips.
module tb_fcvt_int;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_fp;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_int;
    logic        out_nv;
    logic        out_nx;

    int n_tests;
    int n_fail;

    fcvt_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp     (in_fp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_nv    (out_nv),
        .out_nx    (out_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] fp;
        logic [63:0] res;
        logic        nv;
        logic        nx;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency counts the accepting cycle as cycle 1.
    task automatic start_and_wait(input logic [63:0] fp, output int lat);
        in_fp    = fp;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            check_eq("timeout", 64'(out_valid), 64'd1);
            lat = -1;
        end
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        start_and_wait(v.fp, lat);
        check_eq({tag, "_int"}, out_int, v.res);
        check_eq({tag, "_nv"}, 64'(out_nv), 64'(v.nv));
        check_eq({tag, "_nx"}, 64'(out_nx), 64'(v.nx));
        if (v.lat > 0) check_eq({tag, "_lat"}, 64'(lat), 64'(v.lat));
        finish_hs();
        check_eq({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fp     = 64'd0;
        out_ready = 1'b0;

        vecs[0]  = '{64'h3FF0_0000_0000_0000, 64'd1,                  1'b0, 1'b0, 66};
        vecs[1]  = '{64'h4045_6000_0000_0000, 64'd42,                 1'b0, 1'b1, 61};
        vecs[2]  = '{64'hC008_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65};
        vecs[3]  = '{64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2};
        vecs[4]  = '{64'h7FF8_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[5]  = '{64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2};
        vecs[6]  = '{64'hBFE0_0000_0000_0000, 64'd0,                  1'b0, 1'b1, 2};
        vecs[7]  = '{64'h0000_0000_0000_0000, 64'd0,                  1'b0, 1'b0, 2};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'd0,                  1'b0, 1'b0, 2};
        vecs[9]  = '{64'h0000_0000_0000_0001, 64'd0,                  1'b0, 1'b1, 2};
        vecs[10] = '{64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[11] = '{64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[12] = '{64'h43D0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 4};
        vecs[13] = '{64'hC3E0_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2};
        vecs[14] = '{64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0, 4};
        vecs[15] = '{64'hBFF8_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 66};
        vecs[16] = '{64'hFFF8_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[17] = '{64'h3FEF_FFFF_FFFF_FFFF, 64'd0,                  1'b0, 1'b1, 2};

        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_int", out_int, 64'd0);
        check_eq("rst_flags", {62'd0, out_nv, out_nx}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Round trip through the forward int64-to-double mapping (53-bit exact).
        for (int i = 0; i < 8; i++) begin
            logic [63:0] r;
            longint      n;
            r    = {$urandom, $urandom};
            n    = $signed({{11{r[52]}}, r[52:0]});
            v.fp = $realtobits(real'(n));
            v.res = n;
            v.nv = 1'b0;
            v.nx = 1'b0;
            v.lat = 0;
            run_vec($sformatf("rt%0d", i), v);
        end

        // Result held while the consumer stalls; new requests ignored.
        start_and_wait(64'h4045_6000_0000_0000, lat);
        for (int i = 0; i < 10; i++) begin
            in_fp    = 64'h3FF0_0000_0000_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_eq("hold_int", out_int, 64'd42);
            check_eq("hold_nx", 64'(out_nx), 64'd1);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        finish_hs();
        check_eq("hold_idle_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_no_reaccept", 64'(out_valid), 64'd0);

        // Reset during SHIFT aborts the conversion.
        in_fp    = 64'h3FF0_0000_0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_out_int", out_int, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("midrst_no_valid", 64'(seen), 64'd0);
        check_eq("midrst_ready_after", 64'(in_ready), 64'd1);
        run_vec("post_rst", vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fcvt_int.md
FCVT_INT -- requirements
Module: fcvt_int

Interface
REQ-001 No parameters; all widths fixed at 64-bit IEEE 754 double in, 64-bit signed integer out.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request strobe; in_fp is valid when high.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_fp  input  64  IEEE 754 double operand.
REQ-007 out_valid  output  1  out_int, out_nv and out_nx are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_int  output  64  signed two's-complement result.
REQ-010 out_nv  output  1  invalid flag.
REQ-011 out_nx  output  1  inexact flag.

Function
REQ-012 The block shall convert a double to a signed 64-bit integer, rounding toward zero (truncation), as the inverse of the existing int64-to-double converter.
REQ-013 FSM states shall be IDLE, UNPACK, SHIFT, SIGN and DONE.
REQ-014 in_ready shall be high only in IDLE; in_valid is ignored in every other state.
REQ-015 On in_valid && in_ready the block shall capture in_fp and go to UNPACK.
REQ-016 UNPACK shall compute e = exp - 1023 and classify the operand.
REQ-017 Special cases in UNPACK shall go directly to DONE with these results:
  - +/-0 (incl. subnormals with frac=0): out_int 0, no flags.
  - Nonzero |x| < 1 (e < 0, incl. subnormals): out_int 0, out_nx=1.
  - NaN: 0x7FFF_FFFF_FFFF_FFFF, out_nv=1.
  - +Inf, or positive with e >= 63: 0x7FFF_FFFF_FFFF_FFFF, out_nv=1.
  - -Inf, or negative with e >= 63 other than exactly -2^63: 0x8000_0000_0000_0000, out_nv=1.
  - Exactly -2^63 (0xC3E0_0000_0000_0000): 0x8000_0000_0000_0000, no flags.
REQ-018 For 0 <= e <= 62, UNPACK shall load mag = {1'b1, frac, 11'b0}, set a 6-bit count k = 63 - e, clear sticky, and go to SHIFT.
REQ-019 In SHIFT with count != 0, each cycle shall shift mag right by 1, OR the bit shifted out into sticky, and decrement count.
REQ-020 When count == 0, SHIFT shall go to SIGN.
REQ-021 SIGN shall set out_int = sign ? (~mag + 1) : mag and out_nx = sticky, then go to DONE.
REQ-022 Latency from the accepting edge to out_valid high shall be 2 cycles for special cases and k+3 cycles otherwise (maximum 66 cycles, for e = 0).
REQ-023 out_valid shall be high only in DONE.
REQ-024 out_int, out_nv and out_nx shall be held stable while out_valid && !out_ready.
REQ-025 On out_valid && out_ready the block shall return to IDLE; in_ready rises on the following cycle, with no same-cycle re-accept.
REQ-026 out_nv and out_nx shall never both be 1.

Reset
REQ-027 While rst_n = 0, the block shall force:
  - state IDLE
  - in_ready = 1
  - out_valid = 0
  - out_int = 0
  - out_nv = 0, out_nx = 0
  - count, mag and sticky cleared.
REQ-028 Reset asserted mid-conversion shall abort the operation with no result emitted; after release the block shall be in IDLE, ready to accept.

Verification
REQ-029 in_fp = 0x3FF0_0000_0000_0000 (1.0) -> out_int = 1, no flags, out_valid 66 cycles after accept.
REQ-030 in_fp = 0x4045_6000_0000_0000 (42.75) -> out_int = 42 (0x2A), out_nx = 1, out_valid 61 cycles after accept.
REQ-031 in_fp = 0xC008_0000_0000_0000 (-3.0) -> out_int = 0xFFFF_FFFF_FFFF_FFFD, no flags; in_fp = 0xC3E0_0000_0000_0000 -> 0x8000_0000_0000_0000, no flags, 2-cycle latency.
REQ-032 Saturation and flag cases:
  - 0x7FF8_0000_0000_0000 (NaN) -> 0x7FFF_FFFF_FFFF_FFFF, nv=1.
  - 0xFFF0_0000_0000_0000 (-Inf) -> 0x8000_0000_0000_0000, nv=1.
  - 0xBFE0_0000_0000_0000 (-0.5) -> 0, nx=1.
REQ-033 Handshake and reset:
  - Hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready stays 0, a new in_valid is ignored.
  - Assert rst_n = 0 during SHIFT -> out_valid never rises; in_ready = 1 immediately.
  - Compare every result against an integer model of the existing converter's forward mapping (round trip exact for integers representable in 53 bits).
